// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between an ALU
// requester (0) and a load requester (1) through a one-entry registered
// output stage. Conflicts go to requester 1 by default; defining
// WB_ARB_ROUND_ROBIN_EN makes conflicts alternate via a 1-bit pointer.
module wb_port_arbiter #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_WIDTH = 32,
  localparam int unsigned AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [AW-1:0]        req0_ad,
  input  logic [REG_WIDTH-1:0] req0_wd,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [AW-1:0]        req1_ad,
  input  logic [REG_WIDTH-1:0] req1_wd,
  output logic                 req1_ready,
  input  logic                 wb_hold,
  output logic                 we3,
  output logic [AW-1:0]        ad3,
  output logic [REG_WIDTH-1:0] wd3,
  output logic                 stage_busy
);

  logic                 stage_valid;
  logic [AW-1:0]        stage_ad;
  logic [REG_WIDTH-1:0] stage_wd;
  logic                 grant0;
  logic                 grant1;
  logic                 accept;
  logic                 conflict;

  assign conflict = req0_valid && req1_valid;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Pointer names the conflict winner; flips only when a conflict is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (conflict && !wb_hold) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`endif

  // Arbitration: the stage always drains when not held, so any non-held,
  // out-of-reset cycle can accept exactly one write.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !wb_hold) begin
      if (conflict) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
`else
        grant1 = 1'b1;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;

  // Output stage: refill or empty on every non-held edge, frozen while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_ad    <= '0;
      stage_wd    <= '0;
    end else if (!wb_hold) begin
      stage_valid <= accept;
      if (grant1) begin
        stage_ad <= req1_ad;
        stage_wd <= req1_wd;
      end else if (grant0) begin
        stage_ad <= req0_ad;
        stage_wd <= req0_wd;
      end
    end
  end

  assign we3        = stage_valid && (stage_ad != '0) && !wb_hold;
  assign ad3        = stage_ad;
  assign wd3        = stage_wd;
  assign stage_busy = stage_valid;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand-written
// sequences for arbitration conflicts and asynchronous reset.
module tb_wb_port_arbiter;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_ad, req1_ad;
  logic [31:0]   req0_wd, req1_wd;
  logic          req0_ready, req1_ready;
  logic          wb_hold;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [31:0]   wd3;
  logic          stage_busy;

  int checks   = 0;
  int failures = 0;

  wb_port_arbiter #(.REG_COUNT(32), .REG_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ad    (req0_ad),
    .req0_wd    (req0_wd),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_ad    (req1_ad),
    .req1_wd    (req1_wd),
    .req1_ready (req1_ready),
    .wb_hold    (wb_hold),
    .we3        (we3),
    .ad3        (ad3),
    .wd3        (wd3),
    .stage_busy (stage_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          r0v;
    logic [AW-1:0] r0ad;
    logic [31:0]   r0wd;
    logic          r1v;
    logic [AW-1:0] r1ad;
    logic [31:0]   r1wd;
    logic          hold;
    logic          e_r0rdy;
    logic          e_r1rdy;
    logic          e_we3;
    logic [AW-1:0] e_ad3;
    logic [31:0]   e_wd3;
    logic          e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r0v, logic [AW-1:0] r0ad, logic [31:0] r0wd,
                              logic r1v, logic [AW-1:0] r1ad, logic [31:0] r1wd,
                              logic hold, logic e0, logic e1, logic ewe,
                              logic [AW-1:0] ead, logic [31:0] ewd, logic eb);
    vec_t v;
    v.r0v = r0v; v.r0ad = r0ad; v.r0wd = r0wd;
    v.r1v = r1v; v.r1ad = r1ad; v.r1wd = r1wd;
    v.hold = hold;
    v.e_r0rdy = e0; v.e_r1rdy = e1; v.e_we3 = ewe;
    v.e_ad3 = ead; v.e_wd3 = ewd; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic [AW-1:0] r0ad, input logic [31:0] r0wd,
                       input logic r1v, input logic [AW-1:0] r1ad, input logic [31:0] r1wd,
                       input logic hold);
    req0_valid = r0v; req0_ad = r0ad; req0_wd = r0wd;
    req1_valid = r1v; req1_ad = r1ad; req1_wd = r1wd;
    wb_hold = hold;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] exp_ad;
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0);
    #2;
    chk("rst_we3", {31'b0, we3}, 32'd0);
    chk("rst_ad3", {27'b0, ad3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_busy", {31'b0, stage_busy}, 32'd0);
    chk("rst_r0rdy", {31'b0, req0_ready}, 32'd0);
    chk("rst_r1rdy", {31'b0, req1_ready}, 32'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // r0v r0ad r0wd  r1v r1ad r1wd  hold | r0rdy r1rdy we3 ad3 wd3 busy
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 32'h0,        0));
    vq.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 1, 0, 0, 0, 32'h0,        0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 5, 32'hDEADBEEF, 1));
    vq.push_back(mk(0, 0, 0,            1, 0, 32'h12345678, 0, 0, 1, 0, 5, 32'hDEADBEEF, 0));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, 32'h12345678, 1));
    vq.push_back(mk(1, 3, 32'h1,        0, 0, 0,            0, 1, 0, 0, 0, 32'h12345678, 0));
    vq.push_back(mk(1, 3, 32'h2,        0, 0, 0,            0, 1, 0, 1, 3, 32'h1,        1));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 3, 32'h2,        1));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 3, 32'h2,        0));
    vq.push_back(mk(1, 7, 32'hA5,       0, 0, 0,            0, 1, 0, 0, 3, 32'h2,        0));
    vq.push_back(mk(0, 0, 0,            1, 4, 32'h77,       1, 0, 0, 0, 7, 32'hA5,       1));
    vq.push_back(mk(0, 0, 0,            1, 4, 32'h77,       1, 0, 0, 0, 7, 32'hA5,       1));
    vq.push_back(mk(0, 0, 0,            1, 4, 32'h77,       1, 0, 0, 0, 7, 32'hA5,       1));
    vq.push_back(mk(0, 0, 0,            1, 4, 32'h77,       0, 0, 1, 1, 7, 32'hA5,       1));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 4, 32'h77,       1));
    vq.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 4, 32'h77,       0));

    foreach (vq[i]) begin
      drive(vq[i].r0v, vq[i].r0ad, vq[i].r0wd, vq[i].r1v, vq[i].r1ad, vq[i].r1wd, vq[i].hold);
      #1;
      chk($sformatf("v%0d_r0rdy", i), {31'b0, req0_ready}, {31'b0, vq[i].e_r0rdy});
      chk($sformatf("v%0d_r1rdy", i), {31'b0, req1_ready}, {31'b0, vq[i].e_r1rdy});
      chk($sformatf("v%0d_we3", i),   {31'b0, we3},        {31'b0, vq[i].e_we3});
      chk($sformatf("v%0d_ad3", i),   {27'b0, ad3},        {27'b0, vq[i].e_ad3});
      chk($sformatf("v%0d_wd3", i),   wd3,                 vq[i].e_wd3);
      chk($sformatf("v%0d_busy", i),  {31'b0, stage_busy}, {31'b0, vq[i].e_busy});
      next_cycle();
    end

    // Conflict: both requesters valid for 4 cycles, pointer still at requester 0.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
      else       drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      #1;
      if (k < 4) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        chk($sformatf("cf%0d_r0rdy", k), {31'b0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("cf%0d_r1rdy", k), {31'b0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
`else
        chk($sformatf("cf%0d_r0rdy", k), {31'b0, req0_ready}, 32'd0);
        chk($sformatf("cf%0d_r1rdy", k), {31'b0, req1_ready}, 32'd1);
`endif
      end
      if (k > 0) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_ad = ((k - 1) % 2 == 0) ? 5'd1 : 5'd2;
`else
        exp_ad = 5'd2;
`endif
        chk($sformatf("cf%0d_we3", k), {31'b0, we3}, 32'd1);
        chk($sformatf("cf%0d_ad3", k), {27'b0, ad3}, {27'b0, exp_ad});
        chk($sformatf("cf%0d_wd3", k), wd3, (exp_ad == 5'd1) ? 32'h11 : 32'h22);
      end
      next_cycle();
    end
    chk("cf_drain_busy", {31'b0, stage_busy}, 32'd0);

    // Asynchronous reset while the stage holds a write to register 9.
    drive(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b0);
    #1;
    chk("ar_r0rdy", {31'b0, req0_ready}, 32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("ar_pre_we3", {31'b0, we3}, 32'd1);
    chk("ar_pre_ad3", {27'b0, ad3}, 32'd9);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0);
    #1;
    chk("ar_we3", {31'b0, we3}, 32'd0);
    chk("ar_ad3", {27'b0, ad3}, 32'd0);
    chk("ar_wd3", wd3, 32'd0);
    chk("ar_busy", {31'b0, stage_busy}, 32'd0);
    chk("ar_r0rdy_rst", {31'b0, req0_ready}, 32'd0);
    chk("ar_r1rdy_rst", {31'b0, req1_ready}, 32'd0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("ar_post%0d_we3", k), {31'b0, we3}, 32'd0);
      chk($sformatf("ar_post%0d_busy", k), {31'b0, stage_busy}, 32'd0);
      next_cycle();
    end
    drive(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b0);
    #1;
    chk("ar_new_r0rdy", {31'b0, req0_ready}, 32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("ar_new_we3", {31'b0, we3}, 32'd1);
    chk("ar_new_ad3", {27'b0, ad3}, 32'd6);
    chk("ar_new_wd3", wd3, 32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
